// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters, one byte per grant.
// Optional BUSY watchdog is compiled in with `define SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter #(
    parameter int NREQ    = 2,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rx_data,
    output logic               err,
    output logic               spi_send,
    output logic [DW-1:0]      spi_tx,
    output logic [NREQ-1:0]    spi_sel,
    input  logic               spi_done,
    input  logic [DW-1:0]      spi_rx,
    output logic [1:0]         dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   cur;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0]   cnt;
`endif

    // last + k never exceeds 2*NREQ-1, so one conditional subtraction wraps it.
    function automatic int wrap(input int v);
        return (v >= NREQ) ? v - NREQ : v;
    endfunction

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!pick_valid && req[wrap(int'(last) + k)]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(wrap(int'(last) + k));
            end
        end
    end

    assign spi_sel   = gnt;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            last     <= IW'(NREQ - 1);
            cur      <= '0;
            gnt      <= '0;
            ack      <= '0;
            err      <= 1'b0;
            spi_send <= 1'b0;
            spi_tx   <= '0;
            rx_data  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            spi_send <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt    <= NREQ'(1) << pick_idx;
                        spi_tx <= req_data[int'(pick_idx)*DW +: DW];
                        cur    <= pick_idx;
                        state  <= START;
                    end else begin
                        gnt <= '0;
                    end
                end
                START: begin
                    spi_send <= 1'b1;
                    state    <= BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
                    cnt      <= '0;
`endif
                end
                BUSY: begin
                    if (spi_done) begin
                        rx_data <= spi_rx;
                        last    <= cur;
                        state   <= ACK;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (cnt == TW'(TIMEOUT - 1)) begin
                        // Abandon the slave: the requester still loses priority.
                        err   <= 1'b1;
                        last  <= cur;
                        gnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                ACK: begin
                    // gnt stays up through the ack cycle; IDLE drops or replaces it.
                    ack   <= gnt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter (NREQ=2, DW=8, TIMEOUT=20), SPI master modelled by hand.
module tb_spi_xfer_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 8;

    logic               clk;
    logic               nrst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rx_data;
    logic               err;
    logic               spi_send;
    logic [DW-1:0]      spi_tx;
    logic [NREQ-1:0]    spi_sel;
    logic               spi_done;
    logic [DW-1:0]      spi_rx;
    logic [1:0]         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    spi_xfer_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(20)) dut (
        .clk(clk), .nrst(nrst), .req(req), .req_data(req_data),
        .gnt(gnt), .ack(ack), .rx_data(rx_data), .err(err),
        .spi_send(spi_send), .spi_tx(spi_tx), .spi_sel(spi_sel),
        .spi_done(spi_done), .spi_rx(spi_rx), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts from an IDLE cycle with requests already applied; returns in the ack cycle.
    task automatic xfer(input logic [1:0] exp_gnt, input logic [7:0] exp_tx,
                        input logic [7:0] rx, input int lat, input logic [1:0] drop);
        tick();
        check("gnt_start", gnt, exp_gnt);
        check("sel_start", spi_sel, exp_gnt);
        check("tx_start", spi_tx, exp_tx);
        check("state_start", dbg_state, 2'd1);
        check("send_not_yet", spi_send, 1'b0);
        check("err_quiet", err, 1'b0);
        req      = req & ~drop;
        req_data = 16'($urandom_range(0, 65535));
        tick();
        check("send_pulse", spi_send, 1'b1);
        check("state_busy", dbg_state, 2'd2);
        check("ack_busy", ack, 2'b00);
        repeat (lat) tick();
        check("send_once", spi_send, 1'b0);
        check("gnt_busy", gnt, exp_gnt);
        check("tx_stable", spi_tx, exp_tx);
        spi_done = 1'b1;
        spi_rx   = rx;
        tick();
        spi_done = 1'b0;
        spi_rx   = 8'($urandom_range(0, 255));
        check("state_ack", dbg_state, 2'd3);
        check("rx_capture", rx_data, rx);
        check("ack_not_yet", ack, 2'b00);
        tick();
        check("ack_pulse", ack, exp_gnt);
        check("gnt_hold", gnt, exp_gnt);
        check("sel_hold", spi_sel, exp_gnt);
        check("tx_hold", spi_tx, exp_tx);
        check("state_idle", dbg_state, 2'd0);
        check("send_vs_ack", spi_send, 1'b0);
    endtask

    initial begin
        nrst     = 1'b0;
        req      = '0;
        req_data = '0;
        spi_done = 1'b0;
        spi_rx   = '0;
        #1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_ack", ack, 2'b00);
        check("rst_send", spi_send, 1'b0);
        check("rst_rx", rx_data, 8'h00);
        check("rst_tx", spi_tx, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        repeat (3) tick();
        nrst = 1'b1;
        tick();

        // Round robin from reset: 0,1,0,1 with both requests held.
        req      = 2'b11;
        req_data = {8'h5A, 8'h11};
        xfer(2'b01, 8'h11, 8'hC1, 2, 2'b00);
        req_data = {8'h5A, 8'h11};
        xfer(2'b10, 8'h5A, 8'hC2, 4, 2'b00);
        req_data = {8'h22, 8'h33};
        xfer(2'b01, 8'h33, 8'hC3, 1, 2'b00);
        req_data = {8'h44, 8'h55};
        xfer(2'b10, 8'h44, 8'hC4, 5, 2'b00);

        // Single transfer, 16-cycle master, then the lone requester is regranted.
        req      = 2'b01;
        req_data = {8'h00, 8'hA5};
        xfer(2'b01, 8'hA5, 8'h3C, 16, 2'b00);
        req_data = {8'h00, 8'h6B};
        xfer(2'b01, 8'h6B, 8'h7E, 3, 2'b00);
        req = 2'b00;
        tick();
        check("gnt_drop", gnt, 2'b00);
        check("idle_after", dbg_state, 2'd0);

        // Early drop of req[1] after its grant; requester 0 follows.
        req      = 2'b11;
        req_data = {8'h9D, 8'h18};
        xfer(2'b10, 8'h9D, 8'h81, 2, 2'b10);
        check("req_dropped", req, 2'b01);
        req_data = {8'h9D, 8'h18};
        xfer(2'b01, 8'h18, 8'h82, 2, 2'b01);
        tick();
        check("gnt_clear", gnt, 2'b00);

        // Spurious done in IDLE with no requests.
        spi_done = 1'b1;
        spi_rx   = 8'hEE;
        tick();
        spi_done = 1'b0;
        check("spur_state", dbg_state, 2'd0);
        check("spur_ack", ack, 2'b00);
        check("spur_rx", rx_data, 8'h82);
        tick();
        check("spur_ack2", ack, 2'b00);
        check("spur_gnt", gnt, 2'b00);
        check("spur_send", spi_send, 1'b0);

`ifdef SPI_ARB_TIMEOUT_EN
        // Master never answers: err after 20 BUSY cycles, then requester 0 wins.
        req      = 2'b11;
        req_data = {8'h77, 8'h66};
        tick();
        check("to_gnt", gnt, 2'b10);
        tick();
        check("to_send", spi_send, 1'b1);
        repeat (19) tick();
        check("to_busy", dbg_state, 2'd2);
        check("to_err_early", err, 1'b0);
        tick();
        check("to_err", err, 1'b1);
        check("to_gnt_clr", gnt, 2'b00);
        check("to_ack", ack, 2'b00);
        check("to_rx_keep", rx_data, 8'h82);
        check("to_state", dbg_state, 2'd0);
        xfer(2'b01, 8'h66, 8'h99, 3, 2'b11);
        tick();
`endif

        // Asynchronous reset while the send pulse is up.
        req      = 2'b11;
        req_data = {8'hF0, 8'h0F};
        tick();
        tick();
        check("pre_rst_send", spi_send, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_gnt", gnt, 2'b00);
        check("arst_sel", spi_sel, 2'b00);
        check("arst_send", spi_send, 1'b0);
        check("arst_ack", ack, 2'b00);
        check("arst_rx", rx_data, 8'h00);
        check("arst_tx", spi_tx, 8'h00);
        check("arst_state", dbg_state, 2'd0);
        tick();
        nrst = 1'b1;
        tick();
        check("post_rst_gnt", gnt, 2'b01);
        check("post_rst_tx", spi_tx, 8'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Shares one SPI master (shifter plus its control FSM) among NREQ requesters, each owning one slave-select line.
- Round-robin arbitration, one byte-transfer per grant.
- Sequences the master's send/done handshake, routes TX data in and RX data back to the winner.
- Sits between the APB register banks / local clients and the SPI control+shift datapath.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 8, transfer width in bits.
- TIMEOUT, 255, cycles allowed between spi_send and spi_done (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester transfer request (level).
- req_data  in  NREQ*DW  TX byte per requester; slice i = bits [i*DW +: DW].
- gnt  out  NREQ  one-hot grant, held for the whole transfer.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- rx_data  out  DW  received byte, valid from the ack cycle until the next capture.
- err  out  1  one-cycle timeout pulse (0 when feature compiled out).
- spi_send  out  1  one-cycle start pulse to the SPI control FSM.
- spi_tx  out  DW  byte loaded into the shifter.
- spi_sel  out  NREQ  one-hot slave select routing, equals gnt.
- spi_done  in  1  one-cycle completion pulse from the SPI control FSM.
- spi_rx  in  DW  shifter contents, valid in the spi_done cycle.

Behaviour:
- Reset (nrst low, async):
  - state=IDLE.
  - gnt, ack, spi_sel, spi_send, err = 0; spi_tx = 0; rx_data = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, START, BUSY, ACK.
- IDLE:
  - If req != 0, pick the first set req[i] searching i = last+1, last+2, ... modulo NREQ.
  - Register gnt = spi_sel = one-hot(i) and spi_tx = req_data slice i; go to START.
  - Decision uses req sampled in that cycle only.
- START:
  - spi_send = 1 for exactly this cycle; go to BUSY.
  - spi_tx and spi_sel are stable from START until leaving ACK.
- BUSY:
  - Wait for spi_done = 1.
  - On spi_done: capture rx_data = spi_rx, set last = i, go to ACK.
- ACK:
  - ack[i] = 1 for this cycle only.
  - gnt, spi_sel, spi_tx hold; next cycle return to IDLE with gnt = spi_sel = 0.
- Latency: request seen in IDLE at cycle 0 → spi_send at cycle 2 → ack 2 cycles after the spi_done cycle.
- Minimum request-to-request gap: one IDLE cycle.
- req[i] dropped after grant: the transfer still completes, ack[i] still pulses, rx_data is still updated.
- Granted requester keeps req high after ack: it loses to any other pending requester (fairness). If it is the only one pending, it is regranted after one IDLE cycle.
- spi_done in IDLE, START or ACK: ignored.
- req_data changes after the grant cycle: no effect on the current transfer.
- Async reset mid-transfer: all outputs clear immediately. The SPI control FSM shares nrst, so no abort handshake is needed.
- Only one of gnt/ack bits is ever set; ack never coincides with spi_send.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - Counter (width clog2(TIMEOUT+1)) clears in START and increments each BUSY cycle.
  - If it reaches TIMEOUT without spi_done: err = 1 for one cycle, no ack, rx_data unchanged, last = i, return to IDLE with gnt cleared.
  - spi_done arriving in that same cycle wins: normal completion, no err.
- Undefined: no counter; BUSY waits indefinitely; err tied to 0.

Test Plan:
- Reset: nrst=0 mid-BUSY → gnt=0, spi_send=0, ack=0, rx_data=0 within the same cycle. After release, req=2'b11 → gnt=2'b01 first.
- Single transfer: req=2'b01, req_data[7:0]=8'hA5; model returns spi_done 16 cycles after spi_send with spi_rx=8'h3C → spi_tx=8'hA5, one spi_send pulse, ack=2'b01 one cycle, rx_data=8'h3C.
- Round-robin: req=2'b11 held for 4 transfers → grant order 0,1,0,1; no back-to-back grant to the same index.
- Early drop: req[1] deasserted one cycle after the grant → transfer completes, ack[1] pulses, next grant goes only to pending requesters.
- Spurious done: spi_done pulsed in IDLE with req=0 → no ack, rx_data unchanged, state stays IDLE.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT=20): model never returns spi_done → err pulses exactly once, 20 BUSY cycles after START; no ack; the other requester is granted next.
